// File: rtl/fp_add_arbiter.sv
// Round-robin scheduler that shares one external single-precision adder among NREQ requesters.
// Optional subtract mode is enabled by defining FPA_ARB_SUB_EN, which adds the req_sub input.
module fp_add_arbiter #(
  parameter  int XLEN    = 32,
  parameter  int NREQ    = 4,
  parameter  int ADD_LAT = 1,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
`ifdef FPA_ARB_SUB_EN
  input  logic [NREQ-1:0]      req_sub,
`endif
  output logic [XLEN-1:0]      add_a,
  output logic [XLEN-1:0]      add_b,
  input  logic [XLEN-1:0]      add_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 busy
);

  localparam int CNT_W = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [XLEN-1:0]   add_a_q, add_a_d;
  logic [XLEN-1:0]   add_b_q, add_b_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              grant_vld;
  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    cand_idx;
  logic              accept;
  logic [XLEN-1:0]   sel_b;

  // Search starts just past the last served requester so the previous winner has lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == S_IDLE) && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

`ifdef FPA_ARB_SUB_EN
  assign sel_b = req_b[grant_idx*XLEN +: XLEN] ^ {req_sub[grant_idx], {(XLEN-1){1'b0}}};
`else
  assign sel_b = req_b[grant_idx*XLEN +: XLEN];
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          add_a_d  = req_a[grant_idx*XLEN +: XLEN];
          add_b_d  = sel_b;
          rsp_id_d = grant_idx;
          cnt_d    = CNT_W'(ADD_LAT);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d  = add_result;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = rsp_id_q;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: one instance with ADD_LAT=1 and one with ADD_LAT=4,
// each driving a table-based adder stub holding hand-computed single-precision sums.
module tb_fp_add_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst, rst4;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [NREQ-1:0]      req_sub;
  logic                 rsp_ready, rsp_ready4;

  logic [NREQ-1:0]      req_ready, req_ready4;
  logic [XLEN-1:0]      add_a, add_b, add_result;
  logic [XLEN-1:0]      add_a4, add_b4, add_result4;
  logic                 rsp_valid, rsp_valid4;
  logic [IDW-1:0]       rsp_id, rsp_id4;
  logic [XLEN-1:0]      rsp_data, rsp_data4;
  logic                 busy, busy4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000; // 1 + 2 = 3
      {32'h40200000, 32'hBF800000}: return 32'h3FC00000; // 2.5 - 1 = 1.5
      {32'h3F800000, 32'h3F800000}: return 32'h40000000; // 1 + 1 = 2
      {32'h40000000, 32'h3F800000}: return 32'h40400000; // 2 + 1 = 3
      {32'h40400000, 32'h3F800000}: return 32'h40800000; // 3 + 1 = 4
      {32'h40800000, 32'h3F800000}: return 32'h40A00000; // 4 + 1 = 5
      {32'h40400000, 32'hBF800000}: return 32'h40000000; // 3 - 1 = 2
      default:                      return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] fval(input int v);
    case (v)
      1:       return 32'h3F800000;
      2:       return 32'h40000000;
      3:       return 32'h40400000;
      4:       return 32'h40800000;
      5:       return 32'h40A00000;
      default: return 32'h00000000;
    endcase
  endfunction

  assign add_result  = fadd(add_a, add_b);
  assign add_result4 = fadd(add_a4, add_b4);

  fp_add_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .ADD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef FPA_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  fp_add_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .ADD_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst4), .req_valid(req_valid), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b),
`ifdef FPA_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .add_a(add_a4), .add_b(add_b4), .add_result(add_result4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4),
    .rsp_data(rsp_data4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
  endtask

  task automatic set_rr_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, fval(i + 1), 32'h3F800000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants, resps, last_g, lat;
    rst = 1'b1; rst4 = 1'b1;
    req_valid = '0; req_sub = '0; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
    req_a = '0; req_b = '0;
    set_rr_ops();
    repeat (3) @(negedge clk);

    // Reset state
    req_valid = 4'hF;
    #1 check_eq("rst_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_add_a", add_a, 0);
    check_eq("rst_add_b", add_b, 0);
    req_valid = '0;
    @(negedge clk) rst = 1'b0;

    // Test 1: single request from requester 0
    @(negedge clk);
    set_op(0, 32'h3F800000, 32'h40000000);
    req_valid = 4'b0001;
    #1 check_eq("t1_ready", req_ready, 4'b0001);
    @(negedge clk);
    check_eq("t1_wait_ready", req_ready, 0);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_add_a", add_a, 32'h3F800000);
    check_eq("t1_add_b", add_b, 32'h40000000);
    check_eq("t1_wait_rsp_valid", rsp_valid, 0);
    req_valid = '0;
    @(negedge clk);
    check_eq("t1_rsp_valid", rsp_valid, 1);
    check_eq("t1_rsp_id", rsp_id, 0);
    check_eq("t1_rsp_data", rsp_data, 32'h40400000);
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_rsp_done", rsp_valid, 0);
    check_eq("t1_idle", busy, 0);
    rsp_ready = 1'b0;

    // Test 2: mixed signs from requester 2
    set_op(2, 32'h40200000, 32'hBF800000);
    req_valid = 4'b0100;
    #1 check_eq("t2_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check_eq("t2_rsp_id", rsp_id, 2);
    check_eq("t2_rsp_data", rsp_data, 32'h3FC00000);
    rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;

    // Test 3: round robin from a fresh pointer
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    set_rr_ops();
    req_valid = 4'hF; rsp_ready = 1'b1;
    grants = 0; resps = 0; last_g = -3;
    for (int c = 0; c < 18; c++) begin
      #1;
      check_eq("t3_onehot", ($countones(req_ready) <= 1), 1);
      if (req_ready != 0) begin
        check_eq("t3_grant", req_ready, 4'b0001 << (grants % NREQ));
        check_eq("t3_spacing", c - last_g, 3);
        last_g = c;
        grants++;
      end
      if (rsp_valid) begin
        check_eq("t3_rsp_id", rsp_id, resps % NREQ);
        check_eq("t3_rsp_data", rsp_data, fval((resps % NREQ) + 2));
        resps++;
      end
      @(negedge clk);
    end
    check_eq("t3_grants", grants, 6);
    check_eq("t3_resps", resps, 6);
    rsp_ready = 1'b0;

    // Test 4: backpressure (pointer is 1, so requester 2 wins)
    #1 check_eq("t4_ready", req_ready, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check_eq("t4_hold_valid", rsp_valid, 1);
      check_eq("t4_hold_id", rsp_id, 2);
      check_eq("t4_hold_data", rsp_data, 32'h40800000);
      check_eq("t4_hold_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check_eq("t4_next_ready", req_ready, 4'b1000);
    check_eq("t4_rsp_cleared", rsp_valid, 0);
    req_valid = '0;
    @(negedge clk);

    // Test 5: ADD_LAT=4 instance, latency then reset mid-WAIT
    rst = 1'b1; rst4 = 1'b0;
    set_rr_ops();
    req_valid = 4'b0001;
    #1 check_eq("t5_ready", req_ready4, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    lat = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      if (rsp_valid4) lat = n;
      else @(negedge clk);
    end
    check_eq("t5_latency", lat, 5);
    check_eq("t5_rsp_id", rsp_id4, 0);
    check_eq("t5_rsp_data", rsp_data4, 32'h40000000);
    rsp_ready4 = 1'b1;
    @(negedge clk) rsp_ready4 = 1'b0;
    req_valid = 4'hF;
    #1 check_eq("t5_grant1", req_ready4, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_mid_busy", busy4, 1);
    rst4 = 1'b1;
    #1 check_eq("t5_rst_ready", req_ready4, 0);
    @(negedge clk);
    check_eq("t5_after_busy", busy4, 0);
    check_eq("t5_after_rsp_valid", rsp_valid4, 0);
    check_eq("t5_after_data", rsp_data4, 0);
    check_eq("t5_after_add_a", add_a4, 0);
    rst4 = 1'b0;
    #1 check_eq("t5_regrant", req_ready4, 4'b0001);
    req_valid = '0;
    @(negedge clk);
    rst4 = 1'b1;

`ifdef FPA_ARB_SUB_EN
    // Test 6: subtract via sign flip on B
    rst = 1'b0;
    set_op(1, 32'h40400000, 32'h3F800000);
    req_sub = 4'b0010;
    req_valid = 4'b0010;
    #1 check_eq("t6_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0; req_sub = '0;
    check_eq("t6_add_a", add_a, 32'h40400000);
    check_eq("t6_add_b", add_b, 32'hBF800000);
    @(negedge clk);
    check_eq("t6_rsp_id", rsp_id, 1);
    check_eq("t6_rsp_data", rsp_data, 32'h40000000);
    rsp_ready = 1'b1;
    @(negedge clk) rsp_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
Round-robin scheduler that shares one IEEE-754 single-precision adder among NREQ requesters.
- Accepts one operand pair at a time over a per-requester valid/ready handshake.
- Drives the adder operand bus and waits ADD_LAT cycles for the result.
- Returns the sum on a shared response channel tagged with the requester index.
- Sits between the FP client units and the FloatingAddition datapath, which it instantiates externally through add_a/add_b/add_result.

Parameters:
XLEN, 32, operand/result width (IEEE-754 single)
NREQ, 4, number of requesters (2..16)
ADD_LAT, 1, cycles from stable add_a/add_b to a valid add_result sample (>=1)
IDW (localparam), $clog2(NREQ), width of requester index

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
req_a  in  NREQ*XLEN  operand A, requester i at [i*XLEN +: XLEN]
req_b  in  NREQ*XLEN  operand B, same packing
add_a  out  XLEN  operand A to shared adder
add_b  out  XLEN  operand B to shared adder
add_result  in  XLEN  adder output
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  index of requester owning rsp_data
rsp_data  out  XLEN  captured sum
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: FSM=IDLE, rr pointer=NREQ-1 (requester 0 wins first), add_a/add_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, wait counter=0, busy=0. req_ready=0 while rst high.
- IDLE:
  - Grant = first i with req_valid[i], searching from pointer+1 upward, wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally; all other bits are 0.
  - If no req_valid is asserted, req_ready=0 and the FSM stays in IDLE.
  - On an accept (req_valid&req_ready): register req_a/req_b[grant] into add_a/add_b, record grant in rsp_id, counter=ADD_LAT, next=WAIT.
- WAIT:
  - add_a/add_b held stable; req_ready=0; counter decrements each cycle.
  - In the cycle counter==1: capture add_result into rsp_data, next=RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid=0 next cycle, pointer=rsp_id, next=IDLE.
- Latency:
  - Accept edge T: WAIT occupies cycles T+1..T+ADD_LAT; rsp_valid rises in cycle T+ADD_LAT+1.
  - Minimum issue interval is ADD_LAT+2 cycles (IDLE, ADD_LAT×WAIT, RESP with rsp_ready=1).
- Fairness: the pointer updates only on response completion. A continuously requesting requester waits at most NREQ-1 operations.
- No accept while busy. req_ready is 0 in WAIT and RESP regardless of req_valid.
- req_valid may drop before a grant without effect; arbitration is recomputed every IDLE cycle. Requesters must not derive req_valid from req_ready.
- Operand values pass through unmodified (except under the optional feature). No NaN/Inf/denormal handling here; the adder owns arithmetic.
- Reset mid-operation:
  - The in-flight operation is discarded and no response is issued.
  - All state returns to reset values on the next edge.
- rsp_ready asserted outside RESP is ignored.

Optional Feature:
FPA_ARB_SUB_EN:
- Defined: adds input req_sub [NREQ], sampled with the operands on accept. When req_sub[grant]=1, add_b is registered with bit XLEN-1 inverted, so the adder computes A-B.
- Undefined: req_sub port is absent and add_b always equals the granted req_b.

Test Plan:
1. Single request: req_valid=4'b0001, A=0x3F800000, B=0x40000000, ADD_LAT=1, adder stub = real adder -> req_ready[0] in same cycle; rsp_valid 2 cycles after accept with rsp_id=0, rsp_data=0x40400000.
2. Mixed signs: requester 2, A=0x40200000, B=0xBF800000 -> rsp_id=2, rsp_data=0x3FC00000.
3. Round robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; each accept 3 cycles apart; never two req_ready bits high.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable; req_ready=0 throughout; the next accept occurs the cycle after rsp_ready rises.
5. Reset mid-WAIT (ADD_LAT=4, rst pulsed at 2nd WAIT cycle) -> no response; busy=0 and rsp_valid=0 after the edge; with all requesters valid, the next grant is requester 0.
6. With FPA_ARB_SUB_EN: requester 1, A=0x40400000, B=0x3F800000, req_sub=1 -> add_b=0xBF800000, rsp_data=0x40000000.
